// File: rtl/phase_scheduler_pkg.sv
// Shared traffic definitions: phase enumeration, lamp codes and the
// phase sequencing rule. Used by the scheduler and by the lamp driver.
package phase_scheduler_pkg;

  // Signal phases S1..S6, encoded 0..5 on the phase output.
  typedef enum logic [2:0] {
    S1 = 3'd0,  // main-road green
    S2 = 3'd1,  // main-road amber
    S3 = 3'd2,  // side-road green
    S4 = 3'd3,  // side-road amber, pedestrian decision point
    S5 = 3'd4,  // pedestrian-only walk
    S6 = 3'd5   // pedestrian clearance
  } phase_t;

  // Lamp codes as {red, amber, green}.
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_GREEN = 3'b001;

  localparam int PED_W = 10;
  localparam int REM_W = 5;

  // Successor of a phase; 'call' only matters when leaving S4.
  function automatic phase_t next_phase(input phase_t cur, input logic call);
    phase_t nxt;
    case (cur)
      S1:      nxt = S2;
      S2:      nxt = S3;
      S3:      nxt = S4;
      S4:      nxt = call ? S5 : S1;
      S5:      nxt = S6;
      default: nxt = S1;
    endcase
    return nxt;
  endfunction

  // Main-road lamp for a phase; the side road mirrors it in the lamp driver.
  function automatic logic [2:0] main_lamp(input phase_t cur);
    logic [2:0] lamp;
    case (cur)
      S1:      lamp = LAMP_GREEN;
      S2:      lamp = LAMP_AMBER;
      default: lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/phase_scheduler_if.sv
// Control/status bundle between the scheduler and its surroundings.
interface phase_scheduler_if;
  import phase_scheduler_pkg::*;

  logic              tick;
  logic [PED_W-1:0]  ped_req;
  logic              hold;
  logic [2:0]        phase;
  logic [REM_W-1:0]  remaining;
  logic              phase_start;
  logic              ped_pending;
  logic              ped_ack;

  // Master drives the timebase and requests, observes the status.
  modport master (
    output tick, ped_req, hold,
    input  phase, remaining, phase_start, ped_pending, ped_ack
  );

  // Slave is the scheduler itself.
  modport slave (
    input  tick, ped_req, hold,
    output phase, remaining, phase_start, ped_pending, ped_ack
  );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter holding the ticks left in the current phase.
// It never counts below 1: the phase change reloads it instead.
module phase_timer #(
  parameter int               W         = 5,
  parameter logic [W-1:0]     RESET_VAL = 5'd30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         last
);

  logic [W-1:0] value_q;

  // Load has priority over decrement; reset restarts a full first phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= RESET_VAL;
    end else if (load) begin
      value_q <= load_value;
    end else if (dec && (value_q > W'(1))) begin
      value_q <= value_q - W'(1);
    end
  end

  assign value = value_q;
  assign last  = (value_q == W'(1));

endmodule

// File: rtl/phase_scheduler.sv
// Six-phase traffic scheduler with latched pedestrian calls. The phase
// FSM lives here; the countdown is delegated to phase_timer.
module phase_scheduler
  import phase_scheduler_pkg::*;
#(
  parameter int T_GREEN = 30,
  parameter int T_AMBER = 3,
  parameter int T_PED   = 15,
  parameter int T_CLEAR = 3
) (
  input  logic               clk,
  input  logic               rst,
  phase_scheduler_if.slave   bus
);

  // Durations must fit the 5-bit countdown and never be zero.
  if (T_GREEN < 1 || T_GREEN > 31 || T_AMBER < 1 || T_AMBER > 31 ||
      T_PED   < 1 || T_PED   > 31 || T_CLEAR < 1 || T_CLEAR > 31) begin : g_bad_param
    $error("phase_scheduler: phase durations must be within 1..31");
  end

  localparam logic [REM_W-1:0] DUR_GREEN = REM_W'(T_GREEN);
  localparam logic [REM_W-1:0] DUR_AMBER = REM_W'(T_AMBER);
  localparam logic [REM_W-1:0] DUR_PED   = REM_W'(T_PED);
  localparam logic [REM_W-1:0] DUR_CLEAR = REM_W'(T_CLEAR);

  function automatic logic [REM_W-1:0] phase_duration(input phase_t p);
    logic [REM_W-1:0] d;
    case (p)
      S1, S3:  d = DUR_GREEN;
      S2, S4:  d = DUR_AMBER;
      S5:      d = DUR_PED;
      default: d = DUR_CLEAR;
    endcase
    return d;
  endfunction

  phase_t           phase_q, phase_d;
  logic             phase_start_q;
  logic             ped_pending_q;
  logic             ped_ack_q;
  logic             advance;
  logic             phase_done;
  logic             call_now;
  logic             timer_last;
  logic [REM_W-1:0] timer_value;
  logic [REM_W-1:0] load_value;

  // A tick only counts when the schedule is not frozen.
  assign advance    = bus.tick & ~bus.hold;
  assign phase_done = advance & timer_last;
  assign call_now   = |bus.ped_req;

  // Next phase and its duration; a same-cycle button press counts at S4 exit.
  always_comb begin
    phase_d    = next_phase(phase_q, ped_pending_q | call_now);
    load_value = phase_duration(phase_d);
  end

  phase_timer #(
    .W         (REM_W),
    .RESET_VAL (DUR_GREEN)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (phase_done),
    .load_value (load_value),
    .dec        (advance & ~timer_last),
    .value      (timer_value),
    .last       (timer_last)
  );

  // Phase FSM with registered start/ack pulses and the pending-call latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= S1;
      phase_start_q <= 1'b0;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      phase_start_q <= phase_done;
      ped_ack_q     <= 1'b0;
      if (phase_done) begin
        phase_q <= phase_d;
      end
      if (phase_done && phase_d == S5) begin
        // Serving the call: the walk phase itself satisfies any button press.
        ped_pending_q <= 1'b0;
        ped_ack_q     <= 1'b1;
      end else if (phase_q != S5 && call_now) begin
        ped_pending_q <= 1'b1;
      end
    end
  end

  assign bus.phase       = phase_q;
  assign bus.remaining   = timer_value;
  assign bus.phase_start = phase_start_q;
  assign bus.ped_pending = ped_pending_q;
  assign bus.ped_ack     = ped_ack_q;

endmodule

// File: doc/phase_scheduler.md
PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter T_GREEN, default 30, vehicle-green duration in ticks (S1, S3).
REQ-002 Parameter T_AMBER, default 3, vehicle-amber duration in ticks (S2, S4).
REQ-003 Parameter T_PED, default 15, pedestrian-only walk duration in ticks (S5).
REQ-004 Parameter T_CLEAR, default 3, pedestrian clearance duration in ticks (S6).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 tick  in  1  one-cycle timebase enable (1 Hz in system); the only event that advances time.
REQ-008 ped_req  in  10  pedestrian push-buttons P1..P10, level or pulse, any bit = call.
REQ-009 hold  in  1  freeze: while high, ticks are ignored in every phase.
REQ-010 phase  out  3  current phase S1..S6, encoded 0..5.
REQ-011 remaining  out  5  ticks left in current phase, drives the countdown display.
REQ-012 phase_start  out  1  one-cycle pulse in the first cycle of each new phase.
REQ-013 ped_pending  out  1  latched pedestrian call awaiting service.
REQ-014 ped_ack  out  1  one-cycle pulse when a pending call is served (entry to S5).

Function
REQ-015 Each parameter SHALL be in range 1..31; out-of-range values are a static configuration error.
REQ-016 On entering a phase, remaining SHALL be loaded with that phase's duration.
REQ-017 A tick with hold=0 SHALL decrement remaining when remaining>1; when remaining==1 it SHALL transition and reload, so every phase lasts exactly its duration in ticks.
REQ-018 remaining SHALL never read 0 in operation.
REQ-019 Transitions: S1->S2->S3->S4; S4->S5 if a call is pending, else S4->S1; S5->S6->S1.
REQ-020 Effective call at the S4 exit decision = ped_pending OR (|ped_req) in that same cycle.
REQ-021 Any ped_req bit high in S1..S4 or S6 SHALL set ped_pending on the next edge; calls during S5 SHALL be ignored.
REQ-022 Entering S5 SHALL clear ped_pending and pulse ped_ack for exactly one cycle.
REQ-023 phase_start SHALL be registered, high only in the first cycle after a transition edge.
REQ-024 hold=1 together with tick SHALL leave phase, remaining and phase_start unchanged; ped_req latching SHALL continue during hold.
REQ-025 Ticks arriving on consecutive cycles SHALL each be honoured; no tick SHALL be lost or double-counted.

Reset
REQ-026 With rst=1 at an edge: phase=S1, remaining=T_GREEN, ped_pending=0, ped_ack=0, phase_start=0.
REQ-027 rst SHALL override tick, hold and ped_req in the same cycle.
REQ-028 Reset mid-phase SHALL abandon the phase, discard any pending call and restart S1 with a full T_GREEN.

Structure
REQ-029 The phase enumeration S1..S6 and the lamp codes (red 100, amber 010, green 001) SHALL live in a shared traffic package used by this block and the lamp driver.
REQ-030 The loadable down-counter SHALL be a sub-module named phase_timer (load, dec, value, last flag); the phase FSM stays in phase_scheduler.
REQ-031 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-032 Reset, tick every cycle, no calls -> S1 holds 30 ticks, S2 3, S3 30, S4 3, then back to S1; S5 never entered; 66-tick cycle.
REQ-033 Single-cycle ped_req[4] pulse during S1 -> ped_pending=1 through S4; S5 entered with ped_ack pulse, remaining=15; S6 remaining=3; then S1.
REQ-034 ped_req asserted only in the S4 cycle where remaining==1 and tick=1 -> next phase S5 (same-cycle call honoured).
REQ-035 ped_req held high throughout S5 -> ped_pending stays 0 in S5, sets in S6, and the following cycle serves S5 again.
REQ-036 hold=1 for 10 ticks at S3 remaining=12 -> remaining stays 12, then resumes 11 on the first tick after release.
REQ-037 rst asserted in S5 with remaining=7 and ped_pending=1 -> next cycle phase=S1, remaining=30, ped_pending=0.
